ddp_ring_merge: RTL
===================

# ddp_ring_merge

Clocked, parametrised successor to the DDP ring merge stage: it admits packets from NCH external input channels plus the internal loopback channel from the branch stage, arbitrates among them, and buffers the winners in a DEPTH-entry FIFO that feeds the matching-memory stage. It replaces the self-timed two-input merge with a single-clock Send/Ack pipeline element. The internal loopback has priority, which keeps the ring from deadlocking, and round-robin is used among the external channels.

## Interface
- PW, 38: packet width in bits.
- NCH, 2: number of external input channels, ≥1.
- DEPTH, 4: FIFO entries, a power of two, ≥2.
- STARVE_MAX, 8: consecutive internal grants allowed before an external grant is forced; used only with the fairness macro.
- CP  in  1  clock, rising edge. One clock only.
- MR_N  in  1  reset, asynchronous, active-low.
- SEND_IN_EX  in  NCH  external channel i offers a packet.
- PACKET_IN_EX  in  NCH*PW  channel i occupies [i*PW +: PW].
- ACK_OUT_EX  out  NCH  external channel i is accepted this cycle.
- SEND_IN_IN  in  1  internal loopback offers a packet.
- PACKET_IN_IN  in  PW  internal loopback packet.
- ACK_OUT_IN  out  1  internal packet is accepted this cycle.
- SEND_OUT  out  1  FIFO head is valid.
- PACKET_OUT  out  PW  FIFO head packet.
- ACK_IN  in  1  downstream accepts the head.
- COUNT  out  $clog2(DEPTH)+1  FIFO occupancy.

## Operation
- **Transfer rule.** A transfer occurs on a CP rising edge when Send and Ack are both high. A sender holds Send and its packet stable until it is acked. Send must not depend on Ack.
- **Acks.** ACK_OUT_IN and ACK_OUT_EX are combinational from the SEND inputs and registered state. At most one bit is high per cycle, and a bit is never high without its SEND.
- **Push condition.** A push is allowed only when COUNT < DEPTH. When the FIFO is full, all Acks are low, even if a pop happens in the same cycle.
- **Arbitration.** The internal channel wins when SEND_IN_IN is high. Otherwise the first requesting external channel at or after the round-robin pointer rr wins. After an external grant to channel k, rr becomes (k+1) mod NCH. rr is unchanged by internal grants.
- **Pop.** A pop occurs on SEND_OUT & ACK_IN. SEND_OUT = (COUNT != 0). PACKET_OUT is driven from registered storage at the read pointer.
- **Pointers.** Read and write pointers are $clog2(DEPTH) bits and wrap naturally. COUNT is held as a separate register.
- **Simultaneous push and pop.**
  - Below full: COUNT is unchanged.
  - At COUNT == 0: push only. There is no bypass path.
- **Reset.** Asserting MR_N, including mid-operation, immediately clears:
  - the FIFO contents, to 0;
  - the pointers, COUNT, rr and the starve counter;
  - SEND_OUT, PACKET_OUT and COUNT, which read 0.

  While MR_N is low, all Acks are forced to 0. Packets that were in flight are discarded.

## Timing
- **Latency.** A packet pushed at edge t into an empty FIFO drives SEND_OUT and PACKET_OUT from t+1.
- **Throughput.** One packet per cycle in and out.
- **Full recovery.** From full, a pop at edge t raises an Ack in cycle t+1.
- **Combinational paths.** The only combinational input-to-output paths are SEND_IN_* → ACK_OUT_*. There is no path from ACK_IN to any Ack.
- **After reset.** The first edge after MR_N deasserts may already perform a transfer.

## Configuration
- **DDP_MERGE_FAIR_EN defined.**
  - A starve counter, width $clog2(STARVE_MAX+1), increments on each internal grant made while any SEND_IN_EX bit is high.
  - When the counter equals STARVE_MAX, the next grant goes to an external channel chosen by round-robin, even if SEND_IN_IN is high.
  - The counter clears on any external grant, and in any cycle where no SEND_IN_EX bit is high.
- **DDP_MERGE_FAIR_EN undefined.** Strict internal priority applies, and no counter logic exists.

## Structure
- **Shared package.** ddp_pkg holds:
  - DDP_PACKET_W = 38;
  - a packet typedef;
  - the default DEPTH and STARVE_MAX constants, shared with the other ring stages.
- **Sub-module.** ddp_rr_arb, an NCH-wide round-robin arbiter. It takes the request vector and pointer and returns a one-hot grant and the next pointer. The FIFO stays inline.

## Test plan
- **Reset.** Hold MR_N=0 with all SENDs high → all Acks 0, SEND_OUT=0, PACKET_OUT=0, COUNT=0. Release MR_N, push 0x15 on the next edge → SEND_OUT=1 and PACKET_OUT=0x15 one cycle later.
- **Internal priority.** NCH=2, SEND_IN_IN with 0xA, EX0 with 0xB, EX1 with 0xC all high, ACK_IN=1 → output order A, B, C, one per cycle. EX0 is granted before EX1 (rr=0).
- **Full FIFO.** DEPTH=4, ACK_IN=0, push 5 internal packets → 4 are accepted, COUNT=4, ACK_OUT_IN low in cycle 5. Raise ACK_IN for 1 cycle → 5th accepted the following cycle, head order preserved.
- **Round-robin.** EX0 and EX1 continuously requesting, internal idle → grants alternate 0, 1, 0, 1. rr wraps from 1 to 0.
- **Fairness (DDP_MERGE_FAIR_EN, STARVE_MAX=8).** Internal and EX0 continuously requesting → 8 internal grants, then 1 EX0 grant, repeating. With the macro undefined, EX0 is never granted.
- **Reset mid-operation.** COUNT=3 with read pointer at 3 (wrapped) → MR_N pulse low mid-cycle clears SEND_OUT and COUNT asynchronously, and the next pushes start at entry 0.

Source files
------------

// File: rtl/ddp_pkg.sv
// Constants and types shared by the DDP ring stages.
// The merge stage takes its default packet width, FIFO depth and starvation limit from here.
package ddp_pkg;

  localparam int DDP_PACKET_W           = 38;
  localparam int DDP_DEFAULT_DEPTH      = 4;
  localparam int DDP_DEFAULT_STARVE_MAX = 8;

  typedef logic [DDP_PACKET_W-1:0] ddp_packet_t;

endpackage

// File: rtl/ddp_rr_arb.sv
// Round-robin arbiter. It grants the first requester found at or after ptr, and
// next_ptr is the position just past the winner. With no request, the grant is zero
// and the pointer is unchanged.
module ddp_rr_arb #(
  parameter int NCH = 2,
  parameter int RW  = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic [NCH-1:0] req,
  input  logic [RW-1:0]  ptr,
  output logic [NCH-1:0] gnt,
  output logic [RW-1:0]  next_ptr
);

  int   idx;
  logic found;

  always_comb begin
    gnt      = '0;
    next_ptr = ptr;
    found    = 1'b0;
    idx      = 0;
    for (int i = 0; i < NCH; i++) begin
      idx = (int'(ptr) + i) % NCH;
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        next_ptr = RW'((idx + 1) % NCH);
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ddp_ring_merge.sv
// DDP ring merge stage. It merges NCH external channels with the internal loopback into a
// DEPTH-entry FIFO, and the loopback has priority. Define DDP_MERGE_FAIR_EN to add starvation relief.
module ddp_ring_merge
  import ddp_pkg::*;
#(
  parameter int PW         = DDP_PACKET_W,
  parameter int NCH        = 2,
  parameter int DEPTH      = DDP_DEFAULT_DEPTH,
  parameter int STARVE_MAX = DDP_DEFAULT_STARVE_MAX
) (
  input  logic                   CP,
  input  logic                   MR_N,
  input  logic [NCH-1:0]         SEND_IN_EX,
  input  logic [NCH*PW-1:0]      PACKET_IN_EX,
  output logic [NCH-1:0]         ACK_OUT_EX,
  input  logic                   SEND_IN_IN,
  input  logic [PW-1:0]          PACKET_IN_IN,
  output logic                   ACK_OUT_IN,
  output logic                   SEND_OUT,
  output logic [PW-1:0]          PACKET_OUT,
  input  logic                   ACK_IN,
  output logic [$clog2(DEPTH):0] COUNT
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int RW = (NCH > 1) ? $clog2(NCH) : 1;

  logic [PW-1:0]  mem_q [DEPTH];
  logic [PW-1:0]  mem_d [DEPTH];
  logic [AW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]  count_q, count_d;
  logic [RW-1:0]  rr_q, rr_d, rr_next;
  logic [NCH-1:0] arb_gnt, grant_ex;
  logic [PW-1:0]  push_pkt;
  logic           full, ex_any, in_wins, grant_in, push, pop, force_ex;

  ddp_rr_arb #(.NCH(NCH), .RW(RW)) u_arb (
    .req      (SEND_IN_EX),
    .ptr      (rr_q),
    .gnt      (arb_gnt),
    .next_ptr (rr_next)
  );

`ifdef DDP_MERGE_FAIR_EN
  localparam int SW = $clog2(STARVE_MAX + 1);
  logic [SW-1:0] starve_q, starve_d;

  assign force_ex = ex_any && (starve_q == SW'(STARVE_MAX));

  always_comb begin
    starve_d = starve_q;
    if (!ex_any || (|grant_ex)) starve_d = '0;
    else if (grant_in)          starve_d = starve_q + SW'(1);
  end

  always_ff @(posedge CP or negedge MR_N) begin
    if (!MR_N) starve_q <= '0;
    else       starve_q <= starve_d;
  end
`else
  logic cfg_unused;
  assign force_ex   = 1'b0;
  assign cfg_unused = (STARVE_MAX != 0);
`endif

  // A full FIFO blocks every ack, even when a pop happens in the same cycle. This keeps ACK_IN off the ack paths.
  always_comb begin
    full     = (count_q == CW'(DEPTH));
    ex_any   = |SEND_IN_EX;
    in_wins  = SEND_IN_IN && !force_ex;
    grant_in = MR_N && !full && in_wins;
    grant_ex = (MR_N && !full && !in_wins) ? arb_gnt : '0;
    push     = grant_in || (|grant_ex);
    pop      = (count_q != '0) && ACK_IN;
    push_pkt = PACKET_IN_IN;
    for (int i = 0; i < NCH; i++) begin
      if (grant_ex[i]) push_pkt = PACKET_IN_EX[i*PW +: PW];
    end
  end

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    rr_d     = (|grant_ex) ? rr_next : rr_q;
    count_d  = count_q + CW'(push) - CW'(pop);
    if (push) begin
      mem_d[wr_ptr_q] = push_pkt;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + AW'(1);
  end

  always_ff @(posedge CP or negedge MR_N) begin
    if (!MR_N) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      rr_q     <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      rr_q     <= rr_d;
    end
  end

  assign ACK_OUT_IN = grant_in;
  assign ACK_OUT_EX = grant_ex;
  assign SEND_OUT   = (count_q != '0);
  assign PACKET_OUT = mem_q[rd_ptr_q];
  assign COUNT      = count_q;

endmodule
